// File: rtl/char_buffer_arbiter.sv
// Char buffer RAM arbiter: video reads keep direct-RAM timing, the clear engine and terminal
// writes share the idle cycles. Optional host reads are enabled with `define HOST_READ_EN.
module char_buffer_arbiter #(
  parameter int ROWS      = 24,
  parameter int COLS      = 80,
  parameter int ADDR_BITS = 11,
  parameter int BUF_SIZE  = ROWS * COLS,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS-1:0] vid_addr,
  output logic [7:0]           vid_data,
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [7:0]           wr_data,
`ifdef HOST_READ_EN
  input  logic                 wr_we,
  output logic [7:0]           host_rdata,
  output logic                 host_rvalid,
`endif
  output logic                 wr_ack,
  input  logic                 clr_start,
  input  logic [ADDR_BITS-1:0] clr_base,
  input  logic [ADDR_BITS-1:0] clr_count,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata
);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  localparam logic [ADDR_BITS-1:0] BSZ  = ADDR_BITS'(BUF_SIZE);
  localparam logic [ADDR_BITS-1:0] BLST = ADDR_BITS'(BUF_SIZE - 1);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   vid_last_q, vid_last_d;
  logic                   vid_valid_q, vid_valid_d;
  logic                   vid_slot_q, vid_slot_d;
  logic [7:0]             vid_hold_q, vid_hold_d;
  logic [ADDR_BITS-1:0]   cur_q, cur_d;
  logic [ADDR_BITS-1:0]   left_q, left_d;
  logic                   clr_done_q, clr_done_d;
  logic                   rd_pend_q, rd_pend_d;
  logic                   vid_take;
  logic                   wr_is_write;
  logic [ADDR_BITS-1:0]   base_norm;

`ifdef HOST_READ_EN
  assign wr_is_write = wr_we;
  assign host_rvalid = rd_pend_q;
  assign host_rdata  = rd_pend_q ? ram_rdata : 8'h00;
`else
  assign wr_is_write = 1'b1;
`endif

  assign vid_take  = !vid_valid_q || (vid_addr != vid_last_q);
  assign base_norm = (clr_base >= BSZ) ? clr_base - BSZ : clr_base;
  assign clr_busy  = (state_q == S_CLEAR);
  assign clr_done  = clr_done_q;
  assign vid_data  = vid_slot_q ? ram_rdata : vid_hold_q;

  always_comb begin
    state_d     = state_q;
    vid_last_d  = vid_last_q;
    vid_valid_d = vid_valid_q;
    vid_slot_d  = vid_take;
    vid_hold_d  = vid_slot_q ? ram_rdata : vid_hold_q;
    cur_d       = cur_q;
    left_d      = left_q;
    clr_done_d  = 1'b0;
    rd_pend_d   = 1'b0;
    ram_addr    = vid_last_q;
    ram_we      = 1'b0;
    ram_wdata   = 8'h00;
    wr_ack      = 1'b0;

    if (vid_take) begin
      ram_addr    = vid_addr;
      vid_last_d  = vid_addr;
      vid_valid_d = 1'b1;
    end else if (state_q == S_CLEAR) begin
      ram_addr  = cur_q;
      ram_we    = 1'b1;
      ram_wdata = FILL_CHAR;
      cur_d     = (cur_q == BLST) ? '0 : cur_q + 1'b1;
      left_d    = left_q - 1'b1;
      if (left_q == ADDR_BITS'(1)) begin
        state_d    = S_IDLE;
        clr_done_d = 1'b1;
      end
    end else if (wr_req) begin
      ram_addr  = wr_addr;
      ram_we    = wr_is_write;
      ram_wdata = wr_data;
      wr_ack    = 1'b1;
      rd_pend_d = !wr_is_write;
    end

    // a write under the video address forces a re-read next cycle
    if (ram_we && (ram_addr == vid_last_q))
      vid_valid_d = 1'b0;

    if ((state_q == S_IDLE) && clr_start) begin
      if (clr_count != '0) begin
        state_d = S_CLEAR;
        cur_d   = base_norm;
        left_d  = clr_count;
      end else begin
        clr_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      vid_last_q  <= '0;
      vid_valid_q <= 1'b0;
      vid_slot_q  <= 1'b0;
      vid_hold_q  <= 8'h00;
      cur_q       <= '0;
      left_q      <= '0;
      clr_done_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vid_last_q  <= vid_last_d;
      vid_valid_q <= vid_valid_d;
      vid_slot_q  <= vid_slot_d;
      vid_hold_q  <= vid_hold_d;
      cur_q       <= cur_d;
      left_q      <= left_d;
      clr_done_q  <= clr_done_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_char_buffer_arbiter.sv
// Directed bench for char_buffer_arbiter with a synchronous RAM model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_char_buffer_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] vid_addr = '0;
  logic [7:0]  vid_data;
  logic        wr_req = 1'b0;
  logic [10:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic        clr_start = 1'b0;
  logic [10:0] clr_base = '0;
  logic [10:0] clr_count = '0;
  logic        clr_busy;
  logic        clr_done;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
`ifdef HOST_READ_EN
  logic        wr_we = 1'b1;
  logic [7:0]  host_rdata;
  logic        host_rvalid;
`endif

  logic        preload = 1'b1;
  logic [7:0]  mem [0:2047];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  char_buffer_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .vid_addr(vid_addr), .vid_data(vid_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef HOST_READ_EN
    .wr_we(wr_we), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
`endif
    .wr_ack(wr_ack),
    .clr_start(clr_start), .clr_base(clr_base), .clr_count(clr_count),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [7:0] pat(int i);
    return 8'(i) + 8'hDD;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic addr_ok;
    logic ack_busy;
    logic hold_ok;

    // reset state
    cyc(); cyc();
    preload = 1'b0;
    cyc(); #1;
    check("rst_wr_ack", 32'(wr_ack), 0);
    check("rst_clr_busy", 32'(clr_busy), 0);
    check("rst_clr_done", 32'(clr_done), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_vid_data", 32'(vid_data), 0);

    // first video slot, then idle slots
    cyc(); reset_n = 1'b1; #1;
    check("v0_slot_addr", 32'(ram_addr), 0);
    cyc(); #1;
    check("v0_data_c2", 32'(vid_data), 32'h0DD);
    cyc(); #1;
    check("v0_data_hold", 32'(vid_data), 32'h0DD);
    check("v0_idle_we", 32'(ram_we), 0);

    // write request arriving with a video step is deferred one cycle
    cyc(); vid_addr = 11'd10; wr_req = 1'b1; wr_addr = 11'd5; wr_data = 8'h77; #1;
    check("step_no_ack", 32'(wr_ack), 0);
    check("step_addr", 32'(ram_addr), 10);
    cyc(); #1;
    check("wr_ack", 32'(wr_ack), 1);
    check("wr_ram_addr", 32'(ram_addr), 5);
    check("wr_ram_wdata", 32'(ram_wdata), 32'h77);
    check("wr_vid_data", 32'(vid_data), 32'hE7);
    cyc(); wr_req = 1'b0; #1;
    hold_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (vid_data !== 8'hE7) hold_ok = 1'b0;
      cyc(); #1;
    end
    check("vid_uninterrupted", 32'(hold_ok), 1);
    vid_addr = 11'd5;
    cyc(); #1;
    check("readback_5", 32'(vid_data), 32'h77);

    // coherence on a write under the displayed address
    cyc(); vid_addr = 11'd100; #1;
    cyc(); wr_req = 1'b1; wr_addr = 11'd100; wr_data = 8'h42; #1;
    check("coh_before", 32'(vid_data), 32'h41);
    check("coh_ack", 32'(wr_ack), 1);
    cyc(); wr_req = 1'b0; #1;
    cyc(); #1;
    check("coh_after", 32'(vid_data), 32'h42);

`ifdef HOST_READ_EN
    cyc(); wr_req = 1'b1; wr_we = 1'b0; wr_addr = 11'd7; #1;
    check("hr_ack", 32'(wr_ack), 1);
    check("hr_we", 32'(ram_we), 0);
    cyc(); wr_req = 1'b0; wr_we = 1'b1; #1;
    check("hr_valid", 32'(host_rvalid), 1);
    check("hr_data", 32'(host_rdata), 32'hE4);
    cyc(); #1;
    check("hr_valid_off", 32'(host_rvalid), 0);
`endif

    // wrapping clear with a stalled write and an ignored restart
    cyc(); clr_start = 1'b1; clr_base = 11'd1900; clr_count = 11'd80; #1;
    check("clr_start_we", 32'(ram_we), 0);
    n = 0; addr_ok = 1'b1; ack_busy = 1'b0;
    for (int k = 0; k < 200; k++) begin
      cyc(); clr_start = 1'b0;
      if (n == 10) begin
        clr_start = 1'b1; clr_base = 11'd0; clr_count = 11'd5;
      end
      if (n == 20) begin
        wr_req = 1'b1; wr_addr = 11'd300; wr_data = 8'h99;
      end
      #1;
      if (!clr_busy) break;
      if (ram_we !== 1'b1 || ram_wdata !== 8'h20 ||
          ram_addr !== 11'((1900 + n) % 1920)) addr_ok = 1'b0;
      if (wr_ack) ack_busy = 1'b1;
      n++;
    end
    check("clr_len", 32'(n), 80);
    check("clr_addrs", 32'(addr_ok), 1);
    check("clr_no_ack", 32'(ack_busy), 0);
    check("clr_done", 32'(clr_done), 1);
    check("post_clr_ack", 32'(wr_ack), 1);
    check("post_clr_addr", 32'(ram_addr), 300);
    cyc(); wr_req = 1'b0; #1;
    check("clr_done_off", 32'(clr_done), 0);
    check("mem1900", 32'(mem[1900]), 32'h20);
    check("mem1919", 32'(mem[1919]), 32'h20);
    check("mem0", 32'(mem[0]), 32'h20);
    check("mem59", 32'(mem[59]), 32'h20);
    check("mem60", 32'(mem[60]), 32'h19);
    check("mem300", 32'(mem[300]), 32'h99);

    // zero-length clear
    cyc(); clr_start = 1'b1; clr_count = 11'd0; #1;
    cyc(); clr_start = 1'b0; #1;
    check("zero_done", 32'(clr_done), 1);
    check("zero_busy", 32'(clr_busy), 0);

    // base beyond buffer end folds back once
    cyc(); clr_start = 1'b1; clr_base = 11'd1922; clr_count = 11'd3; #1;
    cyc(); clr_start = 1'b0; #1;
    check("fold_a0", 32'(ram_addr), 2);
    cyc(); #1;
    check("fold_a1", 32'(ram_addr), 3);
    cyc(); #1;
    check("fold_a2", 32'(ram_addr), 4);
    cyc(); #1;
    check("fold_done", 32'(clr_done), 1);

    // async reset in the middle of a clear
    cyc(); clr_start = 1'b1; clr_base = 11'd200; clr_count = 11'd80; #1;
    n = 0;
    for (int k = 0; k < 200 && n < 40; k++) begin
      cyc(); clr_start = 1'b0; #1;
      if (ram_we) n++;
    end
    check("mid_writes", 32'(n), 40);
    cyc(); reset_n = 1'b0; #1;
    check("mid_busy", 32'(clr_busy), 0);
    check("mid_we", 32'(ram_we), 0);
    cyc(); cyc(); #1;
    check("mid_mem200", 32'(mem[200]), 32'h20);
    check("mid_mem239", 32'(mem[239]), 32'h20);
    check("mid_mem240", 32'(mem[240]), 32'hCD);
    check("mid_mem279", 32'(mem[279]), 32'hF4);
    check("mid_busy_hold", 32'(clr_busy), 0);
    reset_n = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
